mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Main-memory port of the processor. It sits directly downstream of the fetch and cache stages and serves their miss traffic. It arbitrates between instruction-line fills and data-line fills or writebacks, and drives a single fixed-latency main-memory bus. It returns each completed line to the requester with a one-cycle acknowledge. Data requests have priority over instruction requests, and only one access is outstanding at a time.

## Interface
- MEM_LATENCY, 5, number of cycles `mem_en` is held per access; legal range 1..15
- LINE_W, 128, cache line width in bits
- clk  in  1  single clock; every register updates on its rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- icache_req  in  1  instruction-line fill request; level-sensitive, held until `icache_ack`
- icache_addr  in  16  line address for the instruction fill
- icache_ack  out  1  one-cycle pulse; `icache_line` is valid in the same cycle
- icache_line  out  LINE_W  returned instruction line
- dcache_req  in  1  data request; level-sensitive, held until `dcache_ack`
- dcache_we  in  1  1 = writeback of `dcache_wline`, 0 = fill
- dcache_addr  in  16  line address for the data request
- dcache_wline  in  LINE_W  writeback data
- dcache_ack  out  1  one-cycle pulse; on a fill, `dcache_line` is valid in the same cycle
- dcache_line  out  LINE_W  returned data line
- mem_en  out  1  memory access active
- mem_we  out  1  memory write strobe
- mem_addr  out  16  memory line address
- mem_wdata  out  LINE_W  memory write data
- mem_rdata  in  LINE_W  memory read data; valid on the final `mem_en` cycle
- busy  out  1  high whenever the FSM is not in IDLE

## Operation
- The FSM has three states: IDLE, BUSY, DONE.
- **IDLE**
  - If `dcache_req` is high at the clock edge, go to BUSY and set source = D.
  - Otherwise, if `icache_req` is high, go to BUSY and set source = I.
  - Otherwise, stay in IDLE.
  - On entry to BUSY, register `mem_addr`, `mem_we` (0 for I, `dcache_we` for D) and `mem_wdata` (`dcache_wline` for D, 0 for I). Load the counter with MEM_LATENCY-1.
- **BUSY**
  - `mem_en` = 1.
  - While the counter is nonzero, decrement it on each edge.
  - On the edge where the counter is 0, go to DONE and clear `mem_en`, `mem_we` and `mem_addr`.
  - On that same edge, for a read, capture `mem_rdata` into the line register of the selected source.
- **DONE**
  - Exactly one cycle. The source's ack is high, and the other ack is low.
  - Requests are not sampled in DONE; the requester drops req during this cycle.
  - The next edge always returns the FSM to IDLE.
- Line outputs:
  - `icache_line` and `dcache_line` hold their last captured value until the next capture of the same source.
  - A writeback does not update `dcache_line`.
- Request inputs are sampled only in IDLE. Changes on address or data inputs during BUSY or DONE are ignored, because the access was registered on entry.
- Simultaneous I and D requests in IDLE: D is served first. I stays pending and is granted in the next IDLE cycle, provided D has deasserted by then.
- A requester still asserting req in the IDLE cycle after its own DONE is treated as a new request.
- Counter width is 4 bits. MEM_LATENCY=1 means a single BUSY cycle.

## Timing
- Reset values:
  - State IDLE, counter 0.
  - `mem_en`, `mem_we`, `mem_addr`, `mem_wdata`, both acks, both line registers and `busy` are all 0.
- A request sampled high at edge E0 causes:
  - `mem_en` high during cycles E0..E(MEM_LATENCY-1);
  - ack high in the cycle after edge E(MEM_LATENCY);
  - return to IDLE at E(MEM_LATENCY+1).
- Request-to-ack latency is MEM_LATENCY+1 edges. The minimum spacing between grants is MEM_LATENCY+2 cycles.
- Reset asserted during BUSY or DONE:
  - The access is aborted and `mem_en` and the acks fall immediately.
  - No ack is ever issued for the aborted access.
  - After reset is released, the requester must re-present its request.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **I fill:** MEM_LATENCY=5. `icache_req`=1, `icache_addr`=16'h000C, `mem_rdata`=128'hA5A5...; expected: `mem_en` high for 5 cycles with `mem_addr`=000C and `mem_we`=0; `icache_ack` pulses 6 edges after grant; `icache_line`=A5A5...; `dcache_ack` stays 0.
- **D writeback:** `dcache_req`=1, `dcache_we`=1, `dcache_addr`=16'h0040, `dcache_wline`=128'h1234...; expected: `mem_we`=1 for all 5 BUSY cycles, `mem_wdata`=1234...; `dcache_ack` pulses; `dcache_line` is unchanged from its previous value.
- **Simultaneous requests:** I to 16'h0010 and D fill to 16'h0080 asserted in the same cycle; expected: D is served first (`mem_addr`=0080), then I at 0010, with I's `mem_en` rising exactly 7 cycles after D's rose.
- **Reset abort:** reset driven low in the 3rd BUSY cycle; expected: `mem_en`, `busy` and both acks are 0 immediately; after release, the FSM is in IDLE, and a re-presented request completes normally.
- **MEM_LATENCY=1 back-to-back:** two I requests to 0x0002 and 0x0004; expected: each has a single `mem_en` cycle, acks 3 cycles apart, and each line matches the `mem_rdata` of its own access.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle between the fetch/cache miss ports, the arbiter and the main-memory bus.
// The arbiter takes the slave view; the requesters and memory take the master view.
interface mem_arbiter_if #(
  parameter int LINE_W = 128
);
  logic              icache_req;
  logic [15:0]       icache_addr;
  logic              icache_ack;
  logic [LINE_W-1:0] icache_line;

  logic              dcache_req;
  logic              dcache_we;
  logic [15:0]       dcache_addr;
  logic [LINE_W-1:0] dcache_wline;
  logic              dcache_ack;
  logic [LINE_W-1:0] dcache_line;

  logic              mem_en;
  logic              mem_we;
  logic [15:0]       mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  icache_req, icache_addr,
    input  dcache_req, dcache_we, dcache_addr, dcache_wline,
    input  mem_rdata,
    output icache_ack, icache_line,
    output dcache_ack, dcache_line,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output busy
  );

  modport master (
    output icache_req, icache_addr,
    output dcache_req, dcache_we, dcache_addr, dcache_wline,
    output mem_rdata,
    input  icache_ack, icache_line,
    input  dcache_ack, dcache_line,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Main-memory port: serves I/D line misses one at a time over a fixed-latency bus.
// state | meaning
// IDLE  | sampling requests, data side wins
// BUSY  | mem_en held, latency down-counter running
// DONE  | one-cycle ack to the granted source
module mem_arbiter #(
  parameter int MEM_LATENCY = 5,
  parameter int LINE_W      = 128
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0]        CNT_LOAD  = 4'(MEM_LATENCY - 1);
  localparam logic [LINE_W-1:0] LINE_ZERO = '0;

  state_t     state;
  logic [3:0] latCnt;
  logic       srcIsData;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      latCnt          <= 4'd0;
      srcIsData       <= 1'b0;
      bus.mem_en      <= 1'b0;
      bus.mem_we      <= 1'b0;
      bus.mem_addr    <= 16'h0000;
      bus.mem_wdata   <= LINE_ZERO;
      bus.icache_ack  <= 1'b0;
      bus.dcache_ack  <= 1'b0;
      bus.icache_line <= LINE_ZERO;
      bus.dcache_line <= LINE_ZERO;
      bus.busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.dcache_req) begin
            state         <= BUSY;
            srcIsData     <= 1'b1;
            latCnt        <= CNT_LOAD;
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= bus.dcache_we;
            bus.mem_addr  <= bus.dcache_addr;
            bus.mem_wdata <= bus.dcache_wline;
            bus.busy      <= 1'b1;
          end else if (bus.icache_req) begin
            state         <= BUSY;
            srcIsData     <= 1'b0;
            latCnt        <= CNT_LOAD;
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= bus.icache_addr;
            bus.mem_wdata <= LINE_ZERO;
            bus.busy      <= 1'b1;
          end
        end
        BUSY: begin
          if (latCnt != 4'd0) begin
            latCnt <= latCnt - 4'd1;
          end else begin
            state        <= DONE;
            bus.mem_en   <= 1'b0;
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= 16'h0000;
            // mem_rdata is only valid on this final enable cycle; writebacks leave the line alone
            if (!bus.mem_we) begin
              if (srcIsData) bus.dcache_line <= bus.mem_rdata;
              else           bus.icache_line <= bus.mem_rdata;
            end
            if (srcIsData) bus.dcache_ack <= 1'b1;
            else           bus.icache_ack <= 1'b1;
          end
        end
        DONE: begin
          state          <= IDLE;
          bus.icache_ack <= 1'b0;
          bus.dcache_ack <= 1'b0;
          bus.busy       <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (latency 5 and 1), each checked every cycle
// against a transaction-age model, plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int LW = 128;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic          iReq[2], dReq[2], dWe[2];
  logic [15:0]   iAddr[2], dAddr[2];
  logic [LW-1:0] dWline[2], rdata[2];

  logic          oEn[2], oWe[2], oIack[2], oDack[2], oBusy[2];
  logic [15:0]   oAddr[2];
  logic [LW-1:0] oWdata[2], oIline[2], oDline[2];

  task automatic chk(input string nm, input int g, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got %h want %h at %0t", nm, g, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lat
    localparam int L = (g == 0) ? 5 : 1;

    mem_arbiter_if #(.LINE_W(LW)) bus ();

    mem_arbiter #(.MEM_LATENCY(L), .LINE_W(LW)) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus.slave)
    );

    assign bus.icache_req   = iReq[g];
    assign bus.icache_addr  = iAddr[g];
    assign bus.dcache_req   = dReq[g];
    assign bus.dcache_we    = dWe[g];
    assign bus.dcache_addr  = dAddr[g];
    assign bus.dcache_wline = dWline[g];
    assign bus.mem_rdata    = rdata[g];

    assign oEn[g]    = bus.mem_en;
    assign oWe[g]    = bus.mem_we;
    assign oAddr[g]  = bus.mem_addr;
    assign oWdata[g] = bus.mem_wdata;
    assign oIack[g]  = bus.icache_ack;
    assign oDack[g]  = bus.dcache_ack;
    assign oIline[g] = bus.icache_line;
    assign oDline[g] = bus.dcache_line;
    assign oBusy[g]  = bus.busy;

    // Model: one outstanding transaction described by its age in edges since grant.
    bit            act;
    int            age;
    bit            srcD;
    bit            wr;
    logic [15:0]   a;
    logic [LW-1:0] wd, il, dl;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        act <= 1'b0; age <= 0; srcD <= 1'b0; wr <= 1'b0;
        a <= '0; wd <= '0; il <= '0; dl <= '0;
      end else if (!act) begin
        if (dReq[g]) begin
          act <= 1'b1; age <= 0; srcD <= 1'b1; wr <= dWe[g]; a <= dAddr[g]; wd <= dWline[g];
        end else if (iReq[g]) begin
          act <= 1'b1; age <= 0; srcD <= 1'b0; wr <= 1'b0; a <= iAddr[g]; wd <= '0;
        end
      end else begin
        age <= age + 1;
        if (age + 1 == L && !wr) begin
          if (srcD) dl <= rdata[g];
          else      il <= rdata[g];
        end
        if (age + 1 == L + 1) act <= 1'b0;
      end
    end

    always @(negedge clk) begin
      chk("mem_en",     g, LW'(oEn[g]),   LW'(act && age < L));
      chk("mem_we",     g, LW'(oWe[g]),   LW'(act && age < L && wr));
      chk("mem_addr",   g, LW'(oAddr[g]), (act && age < L) ? LW'(a) : '0);
      chk("mem_wdata",  g, oWdata[g],     wd);
      chk("icache_ack", g, LW'(oIack[g]), LW'(act && age == L && !srcD));
      chk("dcache_ack", g, LW'(oDack[g]), LW'(act && age == L && srcD));
      chk("busy",       g, LW'(oBusy[g]), LW'(act));
      chk("icache_line", g, oIline[g], il);
      chk("dcache_line", g, oDline[g], dl);
    end
  end

  task automatic run_req(input int g, input bit isD, input bit we, input logic [15:0] addr,
                         input logic [LW-1:0] wl, input logic [LW-1:0] rd,
                         output int enCnt, output int ackEdge, output longint ackT,
                         output logic [15:0] firstAddr, output int weCnt, output int otherAcks);
    enCnt = 0; ackEdge = -1; ackT = 0; firstAddr = '0; weCnt = 0; otherAcks = 0;
    rdata[g] = rd;
    if (isD) begin
      dReq[g] = 1'b1; dWe[g] = we; dAddr[g] = addr; dWline[g] = wl;
    end else begin
      iReq[g] = 1'b1; iAddr[g] = addr;
    end
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (oEn[g]) begin
        if (enCnt == 0) firstAddr = oAddr[g];
        enCnt++;
        if (oWe[g]) weCnt++;
      end
      if (isD ? oIack[g] : oDack[g]) otherAcks++;
      if (isD ? oDack[g] : oIack[g]) begin
        ackEdge = i;
        ackT = longint'($time);
        break;
      end
    end
    if (isD) dReq[g] = 1'b0;
    else     iReq[g] = 1'b0;
    checks++;
    if (ackEdge < 0) begin
      errors++;
      $display("FAIL ack_timeout dut%0d got no ack want ack within 40 cycles", g);
    end
  endtask

  initial begin : main
    int            enCnt, ackEdge, weCnt, otherAcks, dRise, iRise;
    longint        t1, t2;
    logic [15:0]   fa, dA, iA;
    logic [LW-1:0] lineA, lineB;
    bit            prevEn;

    for (int g = 0; g < 2; g++) begin
      iReq[g] = 1'b0; dReq[g] = 1'b0; dWe[g] = 1'b0;
      iAddr[g] = '0; dAddr[g] = '0; dWline[g] = '0; rdata[g] = '0;
    end

    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("rst_mem_en", g, LW'(oEn[g]), '0);
      chk("rst_busy",   g, LW'(oBusy[g]), '0);
      chk("rst_iline",  g, oIline[g], '0);
      chk("rst_dline",  g, oDline[g], '0);
      chk("rst_wdata",  g, oWdata[g], '0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Instruction fill at latency 5
    lineA = {4{32'hA5A5A5A5}};
    run_req(0, 1'b0, 1'b0, 16'h000C, '0, lineA, enCnt, ackEdge, t1, fa, weCnt, otherAcks);
    chk("ifill_en_cycles", 0, LW'(enCnt), LW'(5));
    chk("ifill_addr",      0, LW'(fa), LW'(16'h000C));
    chk("ifill_we_cycles", 0, LW'(weCnt), '0);
    chk("ifill_ack_edges", 0, LW'(ackEdge), LW'(6));
    chk("ifill_other_ack", 0, LW'(otherAcks), '0);
    chk("ifill_line",      0, oIline[0], lineA);
    @(negedge clk);

    // Data fill, then a writeback that must leave dcache_line untouched
    lineB = {4{32'hDEADBEEF}};
    run_req(0, 1'b1, 1'b0, 16'h0020, '0, lineB, enCnt, ackEdge, t1, fa, weCnt, otherAcks);
    chk("dfill_line", 0, oDline[0], lineB);
    @(negedge clk);
    run_req(0, 1'b1, 1'b1, 16'h0040, {4{32'h12345678}}, {4{32'h0F0F0F0F}}, enCnt, ackEdge, t1, fa, weCnt, otherAcks);
    chk("wb_we_cycles", 0, LW'(weCnt), LW'(5));
    chk("wb_addr",      0, LW'(fa), LW'(16'h0040));
    chk("wb_wdata",     0, oWdata[0], {4{32'h12345678}});
    chk("wb_ack_edges", 0, LW'(ackEdge), LW'(6));
    chk("wb_dline",     0, oDline[0], lineB);
    chk("wb_iline",     0, oIline[0], lineA);
    @(negedge clk);

    // Simultaneous I and D requests: D first, I granted 7 cycles later
    rdata[0] = {4{32'h0BADF00D}};
    dReq[0] = 1'b1; dWe[0] = 1'b0; dAddr[0] = 16'h0080;
    iReq[0] = 1'b1; iAddr[0] = 16'h0010;
    dRise = -1; iRise = -1; dA = '0; iA = '0; prevEn = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (oEn[0] && !prevEn) begin
        if (dRise < 0) begin dRise = i; dA = oAddr[0]; end
        else begin iRise = i; iA = oAddr[0]; end
      end
      prevEn = oEn[0];
      if (oDack[0]) dReq[0] = 1'b0;
      if (oIack[0]) break;
    end
    iReq[0] = 1'b0; dReq[0] = 1'b0;
    chk("simul_first_addr",  0, LW'(dA), LW'(16'h0080));
    chk("simul_second_addr", 0, LW'(iA), LW'(16'h0010));
    chk("simul_spacing",     0, LW'(iRise - dRise), LW'(7));
    chk("simul_dline",       0, oDline[0], {4{32'h0BADF00D}});
    @(negedge clk);

    // Reset in the third BUSY cycle aborts the access
    iReq[0] = 1'b1; iAddr[0] = 16'h0100; rdata[0] = {4{32'h55AA55AA}};
    repeat (3) @(negedge clk);
    chk("abort_pre_en", 0, LW'(oEn[0]), LW'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("abort_en",    0, LW'(oEn[0]), '0);
    chk("abort_busy",  0, LW'(oBusy[0]), '0);
    chk("abort_iack",  0, LW'(oIack[0]), '0);
    chk("abort_dack",  0, LW'(oDack[0]), '0);
    iReq[0] = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("abort_idle_busy", 0, LW'(oBusy[0]), '0);
    run_req(0, 1'b0, 1'b0, 16'h0100, '0, {4{32'h55AA55AA}}, enCnt, ackEdge, t1, fa, weCnt, otherAcks);
    chk("represent_en_cycles", 0, LW'(enCnt), LW'(5));
    chk("represent_ack_edges", 0, LW'(ackEdge), LW'(6));
    chk("represent_line",      0, oIline[0], {4{32'h55AA55AA}});
    @(negedge clk);

    // Latency 1, back-to-back instruction fills
    lineA = {4{32'hC0FFEE01}};
    lineB = {4{32'h76543210}};
    run_req(1, 1'b0, 1'b0, 16'h0002, '0, lineA, enCnt, ackEdge, t1, fa, weCnt, otherAcks);
    chk("l1_first_en",   1, LW'(enCnt), LW'(1));
    chk("l1_first_addr", 1, LW'(fa), LW'(16'h0002));
    chk("l1_first_ack",  1, LW'(ackEdge), LW'(2));
    chk("l1_first_line", 1, oIline[1], lineA);
    @(negedge clk);
    run_req(1, 1'b0, 1'b0, 16'h0004, '0, lineB, enCnt, ackEdge, t2, fa, weCnt, otherAcks);
    chk("l1_second_en",   1, LW'(enCnt), LW'(1));
    chk("l1_second_addr", 1, LW'(fa), LW'(16'h0004));
    chk("l1_second_line", 1, oIline[1], lineB);
    chk("l1_ack_spacing", 1, LW'((t2 - t1) / 10), LW'(3));
    @(negedge clk);

    // Randomized traffic on both instances, checked every cycle by the models
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        rdata[g] = {$urandom, $urandom, $urandom, $urandom};
        if (iReq[g] && oIack[g]) iReq[g] = 1'b0;
        else if (!iReq[g] && $urandom_range(0, 3) == 0) begin
          iReq[g] = 1'b1; iAddr[g] = 16'($urandom);
        end else if (iReq[g] && $urandom_range(0, 4) == 0) iAddr[g] = 16'($urandom);
        if (dReq[g] && oDack[g]) dReq[g] = 1'b0;
        else if (!dReq[g] && $urandom_range(0, 4) == 0) begin
          dReq[g] = 1'b1; dWe[g] = 1'($urandom); dAddr[g] = 16'($urandom);
          dWline[g] = {$urandom, $urandom, $urandom, $urandom};
        end else if (dReq[g] && $urandom_range(0, 4) == 0) begin
          dAddr[g] = 16'($urandom); dWline[g] = {$urandom, $urandom, $urandom, $urandom};
        end
      end
    end
    for (int g = 0; g < 2; g++) begin
      iReq[g] = 1'b0; dReq[g] = 1'b0;
    end
    repeat (10) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
